uart_rx_frame_ctrl: RTL and testbench

//   Frame controller behind the UART receiver. Consumes its one-cycle byte strobes and

---
 rtl/uart_rx_frame_ctrl_if.sv | 42 ++++
 rtl/uart_rx_frame_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// Interface bundling the byte-strobe input from the UART receiver, the payload
// valid/ready stream and the status outputs of the frame controller.
// The slave modport is the frame controller; the master modport is whoever
// drives the receive strobes and consumes the payload stream.
interface uart_rx_frame_ctrl_if;
    logic       i_rx_valid;
    logic [7:0] i_rx_byte;
    logic       o_pay_valid;
    logic [7:0] o_pay_byte;
    logic       o_pay_last;
    logic       i_pay_ready;
    logic       o_frame_err;
    logic [1:0] o_err_code;
    logic       o_busy;
    logic [7:0] o_frame_cnt;

    modport slave (
        input  i_rx_valid,
        input  i_rx_byte,
        input  i_pay_ready,
        output o_pay_valid,
        output o_pay_byte,
        output o_pay_last,
        output o_frame_err,
        output o_err_code,
        output o_busy,
        output o_frame_cnt
    );

    modport master (
        output i_rx_valid,
        output i_rx_byte,
        output i_pay_ready,
        input  o_pay_valid,
        input  o_pay_byte,
        input  o_pay_last,
        input  o_frame_err,
        input  o_err_code,
        input  o_busy,
        input  o_frame_cnt
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SYNC, LEN, PAYLOAD[LEN], CSUM frames from a stream of
// one-cycle byte strobes. Payload is buffered and only released on the valid/ready
// stream once the 8-bit modular checksum over LEN+payload sums to zero.
// Bad frames are dropped and reported with a one-cycle o_frame_err pulse.
// Optional feature macro: UART_RX_TIMEOUT_EN adds an inter-byte timeout (error code 3)
// while a frame is being received; without it a stalled frame waits indefinitely.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 2000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_rx_frame_ctrl_if.slave bus
);

    localparam int         W         = $clog2(MAX_LEN + 1);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH     = 1 << AW;
    localparam logic [W-1:0] IDX_ONE = W'(1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_BAD_SUM = 2'd2;

    // Reject parameter values the buffer and counters cannot represent
    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 1) begin : g_bad_params
        $error("uart_rx_frame_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CLKS >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] len_q, len_d;
    logic [W-1:0] wr_idx_q, wr_idx_d;
    logic [W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]   sum_q, sum_d;
    logic         pay_valid_q, pay_valid_d;
    logic [7:0]   pay_byte_q, pay_byte_d;
    logic         pay_last_q, pay_last_d;
    logic         frame_err_q, frame_err_d;
    logic [1:0]   err_code_q, err_code_d;
    logic         busy_q, busy_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         wr_en;

    logic [7:0]   mem_q [DEPTH];
    logic [W-1:0] rd_idx_nxt;
    logic [7:0]   csum_total;

    assign rd_idx_nxt = rd_idx_q + IDX_ONE;
    assign csum_total = sum_q + bus.i_rx_byte;

`ifdef UART_RX_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [1:0]    ERR_TIMEOUT = 2'd3;

    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Next-state, datapath and registered-output computation for the frame parser
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        sum_d       = sum_q;
        pay_valid_d = pay_valid_q;
        pay_byte_d  = pay_byte_q;
        pay_last_d  = pay_last_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_valid && bus.i_rx_byte == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (bus.i_rx_valid) begin
                    sum_d = bus.i_rx_byte;
                    if (bus.i_rx_byte == 8'd0 || bus.i_rx_byte > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_BAD_LEN;
                        state_d     = ST_IDLE;
                    end else begin
                        len_d    = bus.i_rx_byte[W-1:0];
                        wr_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.i_rx_valid) begin
                    wr_en    = 1'b1;
                    sum_d    = sum_q + bus.i_rx_byte;
                    wr_idx_d = wr_idx_q + IDX_ONE;
                    if (wr_idx_q == len_q - IDX_ONE) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (bus.i_rx_valid) begin
                    if (csum_total == 8'd0) begin
                        state_d     = ST_DRAIN;
                        rd_idx_d    = '0;
                        pay_valid_d = 1'b1;
                        pay_byte_d  = mem_q[0];
                        pay_last_d  = (len_q == IDX_ONE);
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_BAD_SUM;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.i_rx_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (pay_valid_q && bus.i_pay_ready) begin
                    if (pay_last_q) begin
                        pay_valid_d = 1'b0;
                        pay_last_d  = 1'b0;
                        pay_byte_d  = 8'd0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        rd_idx_d   = rd_idx_nxt;
                        pay_byte_d = mem_q[rd_idx_nxt[AW-1:0]];
                        pay_last_d = (rd_idx_nxt == len_q - IDX_ONE);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef UART_RX_TIMEOUT_EN
        tmo_d = '0;
        if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CSUM) begin
            if (!bus.i_rx_valid) begin
                if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any frame in progress without a report
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            sum_q       <= '0;
            pay_valid_q <= 1'b0;
            pay_byte_q  <= '0;
            pay_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            sum_q       <= sum_d;
            pay_valid_q <= pay_valid_d;
            pay_byte_q  <= pay_byte_d;
            pay_last_q  <= pay_last_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    // Inter-byte silence counter, only meaningful while a frame is being received
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Payload buffer; contents need no reset since only written slots are ever read
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_idx_q[AW-1:0]] <= bus.i_rx_byte;
        end
    end

    assign bus.o_pay_valid = pay_valid_q;
    assign bus.o_pay_byte  = pay_byte_q;
    assign bus.o_pay_last  = pay_last_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_err_code  = err_code_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed frames with scoreboards for the
// payload stream and the error pulses. Honours UART_RX_TIMEOUT_EN if defined.
module tb_uart_rx_frame_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if bus ();

    uart_rx_frame_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] pay_q [$];
    logic [1:0] err_q [$];
    logic [8:0] pay_exp;
    logic [1:0] err_exp;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_byte  = b;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_byte  = 8'd0;
    endtask

    task automatic check_outputs_idle(input string tag);
        check_output({tag, "_pay_valid"}, 32'(bus.o_pay_valid), 32'd0);
        check_output({tag, "_pay_byte"},  32'(bus.o_pay_byte),  32'd0);
        check_output({tag, "_pay_last"},  32'(bus.o_pay_last),  32'd0);
        check_output({tag, "_frame_err"}, 32'(bus.o_frame_err), 32'd0);
        check_output({tag, "_err_code"},  32'(bus.o_err_code),  32'd0);
        check_output({tag, "_busy"},      32'(bus.o_busy),      32'd0);
        check_output({tag, "_frame_cnt"}, 32'(bus.o_frame_cnt), 32'd0);
    endtask

    task automatic wait_drained(input string tag);
        for (int i = 0; i < 40 && bus.o_busy; i++) begin
            @(posedge clk);
            #1;
        end
        check_output({tag, "_drained"}, 32'(bus.o_busy), 32'd0);
    endtask

    // Payload scoreboard: every handshake must match the next expected {last, byte}
    always @(negedge clk) begin
        if (!rst && bus.o_pay_valid && bus.i_pay_ready) begin
            if (pay_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL pay_unexpected: observed byte 0x%0h expected no payload", bus.o_pay_byte);
            end else begin
                pay_exp = pay_q.pop_front();
                check_output("pay_stream", 32'({bus.o_pay_last, bus.o_pay_byte}), 32'(pay_exp));
            end
        end
    end

    // Error scoreboard: every pulse must match the next expected error code
    always @(negedge clk) begin
        if (!rst && bus.o_frame_err) begin
            if (err_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL err_unexpected: observed code %0d expected no error", bus.o_err_code);
            end else begin
                err_exp = err_q.pop_front();
                check_output("err_stream", 32'(bus.o_err_code), 32'(err_exp));
            end
        end
    end

    // Overall time bound so a stuck run still ends
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] sum;
        logic [7:0] b;

        rst             = 1'b1;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_byte   = 8'd0;
        bus.i_pay_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_idle("reset");
        rst = 1'b0;

        // Good frame with ready held high
        $display("[TB] good frame");
        pay_q.push_back({1'b0, 8'h51});
        pay_q.push_back({1'b1, 8'h52});
        apply_stimulus(8'hA5);
        check_output("t1_busy_after_sync", 32'(bus.o_busy), 32'd1);
        apply_stimulus(8'h02);
        apply_stimulus(8'h51);
        apply_stimulus(8'h52);
        apply_stimulus(8'h5B);
        check_output("t1_first_valid", 32'(bus.o_pay_valid), 32'd1);
        check_output("t1_first_byte",  32'(bus.o_pay_byte),  32'h51);
        check_output("t1_first_last",  32'(bus.o_pay_last),  32'd0);
        @(posedge clk); #1;
        check_output("t1_second_valid", 32'(bus.o_pay_valid), 32'd1);
        check_output("t1_second_byte",  32'(bus.o_pay_byte),  32'h52);
        check_output("t1_second_last",  32'(bus.o_pay_last),  32'd1);
        @(posedge clk); #1;
        check_output("t1_done_valid", 32'(bus.o_pay_valid), 32'd0);
        check_output("t1_done_busy",  32'(bus.o_busy),      32'd0);
        check_output("t1_frame_cnt",  32'(bus.o_frame_cnt), 32'd1);
        check_output("t1_no_err",     32'(bus.o_frame_err), 32'd0);

        // Bad checksum
        $display("[TB] bad checksum");
        err_q.push_back(2'd2);
        apply_stimulus(8'hA5);
        apply_stimulus(8'h02);
        apply_stimulus(8'h51);
        apply_stimulus(8'h52);
        apply_stimulus(8'h5C);
        check_output("t2_err_pulse", 32'(bus.o_frame_err), 32'd1);
        check_output("t2_err_code",  32'(bus.o_err_code),  32'd2);
        check_output("t2_no_valid",  32'(bus.o_pay_valid), 32'd0);
        check_output("t2_idle",      32'(bus.o_busy),      32'd0);
        @(posedge clk); #1;
        check_output("t2_pulse_ends", 32'(bus.o_frame_err), 32'd0);
        check_output("t2_code_held",  32'(bus.o_err_code),  32'd2);
        check_output("t2_frame_cnt",  32'(bus.o_frame_cnt), 32'd1);

        // Leading garbage, then bad lengths
        $display("[TB] bad length");
        apply_stimulus(8'h00);
        apply_stimulus(8'hFF);
        check_output("t3_garbage_idle", 32'(bus.o_busy),      32'd0);
        check_output("t3_garbage_err",  32'(bus.o_frame_err), 32'd0);
        err_q.push_back(2'd1);
        apply_stimulus(8'hA5);
        apply_stimulus(8'h00);
        check_output("t3_len0_pulse", 32'(bus.o_frame_err), 32'd1);
        check_output("t3_len0_code",  32'(bus.o_err_code),  32'd1);
        check_output("t3_len0_idle",  32'(bus.o_busy),      32'd0);
        err_q.push_back(2'd1);
        apply_stimulus(8'hA5);
        apply_stimulus(8'h11);
        check_output("t3_len17_pulse", 32'(bus.o_frame_err), 32'd1);
        check_output("t3_len17_code",  32'(bus.o_err_code),  32'd1);

        // Maximum-length frame
        $display("[TB] max length frame");
        sum = 8'h10;
        apply_stimulus(8'hA5);
        apply_stimulus(8'h10);
        for (int i = 0; i < 16; i++) begin
            b   = 8'(i * 3 + 1);
            sum = sum + b;
            pay_q.push_back({(i == 15), b});
            apply_stimulus(b);
        end
        check_output("t3_max_busy", 32'(bus.o_busy), 32'd1);
        apply_stimulus(8'(8'd0 - sum));
        check_output("t3_max_valid", 32'(bus.o_pay_valid), 32'd1);
        wait_drained("t3_max");
        check_output("t3_max_cnt", 32'(bus.o_frame_cnt), 32'd2);

        // Backpressure with an overrun byte during drain
        $display("[TB] backpressure and overrun");
        bus.i_pay_ready = 1'b0;
        pay_q.push_back({1'b0, 8'h51});
        pay_q.push_back({1'b1, 8'h52});
        apply_stimulus(8'hA5);
        apply_stimulus(8'h02);
        apply_stimulus(8'h51);
        apply_stimulus(8'h52);
        apply_stimulus(8'h5B);
        for (int i = 0; i < 5; i++) begin
            check_output("t4_hold_valid", 32'(bus.o_pay_valid), 32'd1);
            check_output("t4_hold_byte",  32'(bus.o_pay_byte),  32'h51);
            check_output("t4_hold_last",  32'(bus.o_pay_last),  32'd0);
            if (i == 2) begin
                err_q.push_back(2'd0);
                apply_stimulus(8'h77);
                check_output("t4_overrun_pulse", 32'(bus.o_frame_err), 32'd1);
                check_output("t4_overrun_code",  32'(bus.o_err_code),  32'd0);
                check_output("t4_overrun_busy",  32'(bus.o_busy),      32'd1);
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.i_pay_ready = 1'b1;
        wait_drained("t4");
        check_output("t4_frame_cnt", 32'(bus.o_frame_cnt), 32'd3);
        check_output("t4_pay_all",   32'(pay_q.size()),    32'd0);

        // Stalled frame
        $display("[TB] stalled frame");
        apply_stimulus(8'hA5);
        apply_stimulus(8'h02);
        apply_stimulus(8'h51);
`ifdef UART_RX_TIMEOUT_EN
        err_q.push_back(2'd3);
        repeat (1999) @(posedge clk);
        #1;
        check_output("t5_before_timeout", 32'(bus.o_frame_err), 32'd0);
        check_output("t5_busy_waiting",   32'(bus.o_busy),      32'd1);
        @(posedge clk); #1;
        check_output("t5_timeout_pulse", 32'(bus.o_frame_err), 32'd1);
        check_output("t5_timeout_code",  32'(bus.o_err_code),  32'd3);
        check_output("t5_timeout_idle",  32'(bus.o_busy),      32'd0);
`else
        repeat (2100) @(posedge clk);
        #1;
        check_output("t5_still_busy", 32'(bus.o_busy),     32'd1);
        check_output("t5_code_held",  32'(bus.o_err_code), 32'd0);
`endif

        // Reset, including mid-frame, then a clean frame
        $display("[TB] reset behaviour");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_outputs_idle("t6_reset_a");
        apply_stimulus(8'hA5);
        apply_stimulus(8'h02);
        apply_stimulus(8'h51);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_outputs_idle("t6_reset_mid");
        pay_q.push_back({1'b0, 8'h51});
        pay_q.push_back({1'b1, 8'h52});
        apply_stimulus(8'hA5);
        apply_stimulus(8'h02);
        apply_stimulus(8'h51);
        apply_stimulus(8'h52);
        apply_stimulus(8'h5B);
        check_output("t6_valid", 32'(bus.o_pay_valid), 32'd1);
        wait_drained("t6");
        check_output("t6_frame_cnt", 32'(bus.o_frame_cnt), 32'd1);

        @(posedge clk); #1;
        check_output("end_pay_queue", 32'(pay_q.size()), 32'd0);
        check_output("end_err_queue", 32'(err_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
